// File: rtl/bpu_mem_io.sv
// rtl/bpu_mem_io.sv - BatPU2 data memory with memory-mapped I/O ports
//
// Address map: RAM occupies 0..D-1 with D = 2^ADDR_W - IO_PORTS; port p sits at
// address D+p. Reads are registered (rd_data/rd_valid); writes to a port update
// its output register and pulse out_strobe[p] for one cycle.
//
// Build option: define BPU_MEMIO_CLEAR_EN to build the post-reset RAM clear
// engine (busy is high until every RAM word has been zeroed).
//
// Ports:
//   clk, async_rst        clock, asynchronous active-high reset
//   clk_en                gates all CPU-visible state (not the input synchronisers)
//   mem_req, mem_we       read / write request at addr (wr_data for writes)
//   rd_data, rd_valid     registered read data and its valid flag
//   busy                  clear engine running; requests are dropped
//   port_in               external inputs, port p at [p*DATA_W +: DATA_W]
//   port_out, out_strobe  output registers and per-port write pulses
module bpu_mem_io #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int IO_PORTS = 1
) (
    input  logic                         clk,
    input  logic                         async_rst,
    input  logic                         clk_en,
    input  logic                         mem_req,
    input  logic                         mem_we,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         busy,
    input  logic [IO_PORTS*DATA_W-1:0]   port_in,
    output logic [IO_PORTS*DATA_W-1:0]   port_out,
    output logic [IO_PORTS-1:0]          out_strobe
);

    localparam int                D      = (1 << ADDR_W) - IO_PORTS;
    localparam logic [ADDR_W-1:0] D_A    = ADDR_W'(D);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(D - 1);

    logic [DATA_W-1:0]          ram [0:D-1];
    logic [IO_PORTS*DATA_W-1:0] sync1, sync2;

    logic              accept;
    logic              is_io;
    logic [ADDR_W-1:0] port_idx;
    logic [DATA_W-1:0] io_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [DATA_W-1:0] ram_wd;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    assign accept   = clk_en & ~busy;
    assign is_io    = (addr >= D_A);
    assign port_idx = addr - D_A;

`ifdef BPU_MEMIO_CLEAR_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // One RAM word is zeroed per enabled cycle; the counter stops at D-1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        case (state)
            S_CLEAR: begin
                if (clk_en) begin
                    clr_we = 1'b1;
                    if (cnt == LAST_A) state_nx = S_IDLE;
                    else               cnt_nx   = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state == S_CLEAR);
    assign clr_addr = cnt;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Single RAM write port shared by the clear engine and CPU writes; the two
    // never collide because CPU requests are not accepted while busy.
    assign ram_we = clr_we | (accept & mem_we & ~is_io);
    assign ram_wa = clr_we ? clr_addr : addr;
    assign ram_wd = clr_we ? '0 : wr_data;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
    end

    always_comb begin
        io_rd = '0;
        for (int p = 0; p < IO_PORTS; p++) begin
            if (port_idx == ADDR_W'(p)) io_rd = sync2[p*DATA_W +: DATA_W];
        end
    end

    // Read-first: ram[addr] here is the value before any same-edge write.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clk_en) begin
            rd_valid <= accept & mem_req;
            if (accept & mem_req) rd_data <= is_io ? io_rd : ram[addr];
        end
    end

    // Strobes clear on every clock edge so a pulse lasts one clk even when
    // clk_en drops on the following cycle.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            port_out   <= '0;
            out_strobe <= '0;
        end else begin
            out_strobe <= '0;
            for (int p = 0; p < IO_PORTS; p++) begin
                if (accept && mem_we && is_io && port_idx == ADDR_W'(p)) begin
                    port_out[p*DATA_W +: DATA_W] <= wr_data;
                    out_strobe[p]                <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= port_in;
            sync2 <= sync1;
        end
    end

endmodule

// File: tb/tb_bpu_mem_io.sv
// tb/tb_bpu_mem_io.sv - self-checking bench for bpu_mem_io
module tb_bpu_mem_io;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 8;
    localparam int IO_PORTS = 2;
    localparam int D        = 254;
`ifdef BPU_MEMIO_CLEAR_EN
    localparam int CLR_LEN  = 254;
    localparam bit CLR      = 1'b1;
`else
    localparam int CLR_LEN  = 0;
    localparam bit CLR      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        async_rst;
    logic        clk_en;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic [1:0]  out_strobe;

    bpu_mem_io #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_PORTS(IO_PORTS)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .mem_req(mem_req), .mem_we(mem_we), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .port_in(port_in), .port_out(port_out), .out_strobe(out_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_mem   [0:D-1];
    bit         m_known [0:D-1];
    logic [7:0] m_rd;
    bit         m_rd_known;
    bit         m_valid;
    logic [7:0] m_pout  [0:1];
    logic [1:0] m_strobe;
    bit         m_busy;
    int         m_cnt;
    logic [7:0] s1 [0:1];
    logic [7:0] s2 [0:1];

    typedef struct {
        bit         rq;
        bit         we;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        bit         exp_valid;
        logic [1:0] exp_strobe;
        logic [15:0] exp_pout;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rd = 8'h00; m_rd_known = 1'b1; m_valid = 1'b0;
        m_pout[0] = 8'h00; m_pout[1] = 8'h00; m_strobe = 2'b00;
        m_busy = CLR; m_cnt = 0;
        s1[0] = 8'h00; s1[1] = 8'h00; s2[0] = 8'h00; s2[1] = 8'h00;
        if (!CLR) for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    endtask

    // Effect of one clock edge given the inputs currently applied.
    task automatic model_edge();
        bit acc;
        int a;
        acc = clk_en && !m_busy;
        a = int'(addr);
        if (clk_en && m_busy) begin
            m_mem[m_cnt] = 8'h00;
            m_known[m_cnt] = 1'b1;
            if (m_cnt == D - 1) m_busy = 1'b0;
            else                m_cnt++;
        end
        m_strobe = 2'b00;
        if (clk_en) m_valid = acc && mem_req;
        if (acc && mem_req) begin
            if (a < D) begin m_rd = m_mem[a]; m_rd_known = m_known[a]; end
            else       begin m_rd = s2[a - D]; m_rd_known = 1'b1; end
        end
        if (acc && mem_we) begin
            if (a < D) begin m_mem[a] = wr_data; m_known[a] = 1'b1; end
            else begin m_pout[a - D] = wr_data; m_strobe[a - D] = 1'b1; end
        end
        s2[0] = s1[0]; s2[1] = s1[1];
        s1[0] = port_in[7:0]; s1[1] = port_in[15:8];
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".rd_valid"}, 16'(rd_valid), 16'(m_valid));
        if (m_rd_known) chk({tag, ".rd_data"}, 16'(rd_data), 16'(m_rd));
        chk({tag, ".busy"}, 16'(busy), 16'(m_busy));
        chk({tag, ".port_out"}, port_out, {m_pout[1], m_pout[0]});
        chk({tag, ".out_strobe"}, 16'(out_strobe), 16'(m_strobe));
    endtask

    task automatic drive(input string tag, input bit ce, input bit rq, input bit we,
                         input logic [7:0] a, input logic [7:0] wd);
        clk_en = ce; mem_req = rq; mem_we = we; addr = a; wr_data = wd;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset_check(input string tag);
        #2;
        async_rst = 1'b1;
        #1;
        chk({tag, ".rd_data"}, 16'(rd_data), 16'h0);
        chk({tag, ".rd_valid"}, 16'(rd_valid), 16'h0);
        chk({tag, ".port_out"}, port_out, 16'h0);
        chk({tag, ".out_strobe"}, 16'(out_strobe), 16'h0);
        chk({tag, ".busy"}, 16'(busy), 16'(CLR));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        async_rst = 1'b0;
    endtask

    // Runs while busy, counting enabled cycles; random requests must be ignored.
    task automatic run_clear(input int stop_at, output int n);
        int guard;
        bit ce;
        n = 0;
        guard = 0;
        while (busy && guard < 2000 && n != stop_at) begin
            ce = ($urandom_range(0, 3) != 0);
            if (ce) n++;
            drive("clear", ce, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            guard++;
        end
    endtask

    function automatic logic [7:0] rand_addr();
        int r;
        r = $urandom_range(0, 3);
        if (r < 2)  return 8'($urandom_range(0, 7));
        if (r == 2) return 8'($urandom_range(250, 255));
        return 8'($urandom);
    endfunction

    initial begin
        int n;
        async_rst = 1'b1; clk_en = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        addr = 8'h00; wr_data = 8'h00; port_in = 16'h0000;
        for (int i = 0; i < D; i++) begin m_mem[i] = 8'h00; m_known[i] = 1'b0; end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset.rd_data", 16'(rd_data), 16'h0);
        chk("reset.rd_valid", 16'(rd_valid), 16'h0);
        chk("reset.port_out", port_out, 16'h0);
        chk("reset.out_strobe", 16'(out_strobe), 16'h0);
        chk("reset.busy", 16'(busy), 16'(CLR));
        @(negedge clk);
        async_rst = 1'b0;

        run_clear(-1, n);
        chk("clear_len", 16'(n), 16'(CLR_LEN));

`ifdef BPU_MEMIO_CLEAR_EN
        drive("clr_rd0", 1, 1, 0, 8'd0, 8'h00);
        chk("clr_rd0.data", 16'(rd_data), 16'h00);
        chk("clr_rd0.valid", 16'(rd_valid), 16'h1);
        drive("clr_rd100", 1, 1, 0, 8'd100, 8'h00);
        chk("clr_rd100.data", 16'(rd_data), 16'h00);
        drive("clr_rd253", 1, 1, 0, 8'd253, 8'h00);
        chk("clr_rd253.data", 16'(rd_data), 16'h00);
        drive("clr_idle", 1, 0, 0, 8'd0, 8'h00);
        chk("clr_idle.valid", 16'(rd_valid), 16'h0);
`endif

        // Directed vectors: RAM, read-first, output port, input port
        tbl[0] = '{1'b0, 1'b1, 8'd17,  8'hA5, 8'h00, 1'b0, 2'b00, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 8'd17,  8'h00, 8'hA5, 1'b1, 2'b00, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 8'd17,  8'h3C, 8'hA5, 1'b1, 2'b00, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 8'd17,  8'h00, 8'h3C, 1'b1, 2'b00, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 8'd255, 8'h55, 8'h00, 1'b0, 2'b10, 16'h5500};
        tbl[5] = '{1'b0, 1'b0, 8'd0,   8'h00, 8'h00, 1'b0, 2'b00, 16'h5500};
        tbl[6] = '{1'b1, 1'b0, 8'd254, 8'h00, 8'h07, 1'b1, 2'b00, 16'h5500};
        tbl[7] = '{1'b1, 1'b0, 8'd255, 8'h00, 8'h99, 1'b1, 2'b00, 16'h5500};
        tbl[8] = '{1'b1, 1'b1, 8'd255, 8'h66, 8'h99, 1'b1, 2'b10, 16'h6600};
        tbl[9] = '{1'b0, 1'b0, 8'd0,   8'h00, 8'h00, 1'b0, 2'b00, 16'h6600};
        port_in = 16'h9907;
        for (int i = 0; i < 10; i++) begin
            drive($sformatf("vec%0d", i), 1, tbl[i].rq, tbl[i].we, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d.valid", i), 16'(rd_valid), 16'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("vec%0d.rd", i), 16'(rd_data), 16'(tbl[i].exp_rd));
            chk($sformatf("vec%0d.strobe", i), 16'(out_strobe), 16'(tbl[i].exp_strobe));
            chk($sformatf("vec%0d.pout", i), port_out, tbl[i].exp_pout);
        end

        // Input synchroniser latency: new value visible on the third read
        port_in = 16'h993E;
        drive("sync0", 1, 1, 0, 8'd254, 8'h00);
        chk("sync0.rd", 16'(rd_data), 16'h07);
        drive("sync1", 1, 1, 0, 8'd254, 8'h00);
        chk("sync1.rd", 16'(rd_data), 16'h07);
        drive("sync2", 1, 1, 0, 8'd254, 8'h00);
        chk("sync2.rd", 16'(rd_data), 16'h3E);

        // clk_en stall: nothing changes, then one access goes through
        for (int i = 0; i < 3; i++) begin
            drive("stall", 0, 1, 1, 8'd254, 8'hAA);
            chk("stall.strobe", 16'(out_strobe), 16'h0);
            chk("stall.pout", port_out, 16'h6600);
            chk("stall.valid", 16'(rd_valid), 16'h1);
        end
        drive("unstall", 1, 1, 1, 8'd254, 8'hAA);
        chk("unstall.strobe", 16'(out_strobe), 16'h1);
        chk("unstall.pout", port_out, 16'h66AA);
        chk("unstall.rd", 16'(rd_data), 16'h3E);
        drive("after", 0, 0, 0, 8'd0, 8'h00);
        chk("after.strobe", 16'(out_strobe), 16'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) port_in = 16'($urandom);
            drive("rand", ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                  rand_addr(), 8'($urandom));
        end

        // Reset during operation, then mid-clear, then a full clear
        drive("pre_rst_wr", 1, 0, 1, 8'd254, 8'h5A);
        drive("pre_rst_rd", 1, 1, 0, 8'd255, 8'h00);
        apply_reset_check("rst_op");
        run_clear(100, n);
        chk("clear_part", 16'(n), 16'(CLR ? 100 : 0));
        apply_reset_check("rst_mid");
        run_clear(-1, n);
        chk("clear_restart_len", 16'(n), 16'(CLR_LEN));

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) port_in = 16'($urandom);
            drive("rand2", ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                  rand_addr(), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpu_mem_io.md
# bpu_mem_io

Parametrised data-memory and memory-mapped I/O subsystem for the BatPU2 CPU data port. It decodes the CPU data address into a synchronous RAM region and a block of I/O ports at the top of the address space. It provides registered reads with a valid flag, per-port output registers with write strobes, and synchronised input ports. An optional clear engine can zero the RAM after reset.

## Interface

- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 8: data address width; address space is 2^ADDR_W words.
- `IO_PORTS`, 1: number of I/O ports mapped at the top of the address space (1..2^ADDR_W-1).
- `clk` in 1: system clock; the only clock.
- `async_rst` in 1: asynchronous, active-high reset.
- `clk_en` in 1: global clock enable; gates all CPU-visible state except the input synchronisers.
- `mem_req` in 1: read request at `addr`.
- `mem_we` in 1: write request at `addr` with `wr_data`.
- `addr` in ADDR_W: data address.
- `wr_data` in DATA_W: write data.
- `rd_data` out DATA_W: registered read data.
- `rd_valid` out 1: `rd_data` updated by the previous accepted read.
- `busy` out 1: clear engine active; requests are ignored.
- `port_in` in IO_PORTS*DATA_W: external inputs; port p occupies bits [p*DATA_W +: DATA_W].
- `port_out` out IO_PORTS*DATA_W: output registers, same packing.
- `out_strobe` out IO_PORTS: one-cycle pulse per port on an accepted write.

## Operation

- RAM depth D = 2^ADDR_W - IO_PORTS. Addresses 0..D-1 are RAM; address A >= D is I/O port p = A - D.
- A request is accepted when `clk_en`=1 and `busy`=0. Requests outside acceptance are dropped, not queued.
- Read of RAM: `rd_data` <= ram[A]. Read of port p: `rd_data` <= synchronised `port_in` of port p. Output registers are not readable.
- Write to RAM: ram[A] <= `wr_data`. Write to port p: `port_out`[p] <= `wr_data` and `out_strobe`[p] = 1 for the next cycle.
- Simultaneous read and write to the same RAM address is read-first: `rd_data` gets the old contents.
- Simultaneous read of port p and write to port p: the read returns the input, and the write updates the output independently.
- Input synchroniser: two flops per bit, clocked every `clk` and independent of `clk_en`.
- Reset values: `rd_data`=0, `rd_valid`=0, `port_out`=0, `out_strobe`=0, synchronisers=0. `busy`=1 if clear is compiled in, otherwise 0.
- Clear FSM (when enabled) has two states:
  - CLEAR: entered on reset. Counter starts at 0 and writes ram[cnt]=0 on each `clk_en` cycle. When cnt=D-1 is written, go to IDLE.
  - IDLE: `busy`=0; normal operation. Stays here until the next reset.
- Reset asserted mid-clear restarts the FSM from cnt=0.
- Counter width is ADDR_W with no wrap beyond D-1.

## Timing

- Read latency is 1 accepted cycle. Request at edge N (with `clk_en`=1) gives `rd_data` valid and `rd_valid`=1 after edge N.
- `rd_valid` stays high until the next `clk_en`=1 edge. It is then cleared unless another read is accepted.
- `rd_data` holds its value between reads.
- Back-to-back reads are supported at one per accepted cycle.
- `out_strobe`[p] is high for exactly one `clk` cycle after the accepting edge.
- `port_out` changes on that same edge.
- `port_in` change to readable value: 2 `clk` edges. It is read at the following accepted request.
- Clear duration: D `clk_en`=1 cycles after reset release. `busy` falls on the edge that writes ram[D-1].

## Configuration

- `BPU_MEMIO_CLEAR_EN` defined: the clear FSM is built, and RAM reads as 0 after the clear completes.
- Not defined: there is no FSM or counter, `busy` is tied to 0, and RAM contents after reset are undefined. Requests are accepted on the first `clk_en` cycle after reset.

## Test plan

Defaults throughout: DATA_W=8, ADDR_W=8, IO_PORTS=2, so D=254 and the ports sit at addresses 254 and 255.

- **Clear:** with the macro defined, release reset.
  - `busy` is 1 for exactly 254 `clk_en` cycles.
  - Reads of addresses 0, 100 and 253 then return 0x00 with `rd_valid` pulsing.
- **RAM write/read:** write 0xA5 to address 17, then read 17 → `rd_data`=0xA5 one cycle later.
  - Then issue a simultaneous write of 0x3C and read at 17 → returns 0xA5; a subsequent read returns 0x3C.
- **Output port:** write 0x55 to address 255 → `port_out`[1]=0x55 and `out_strobe`=2'b10 for one cycle; `port_out`[0] is unchanged.
- **Input port:** set `port_in`[0]=0x07 and wait 2 clocks, then read address 254 → 0x07.
  - Reading 255 returns `port_in`[1], not 0x55.
- **clk_en stall:** hold `clk_en`=0 while asserting a read and a write → no state change and no strobe.
  - Raise `clk_en` → a single accepted access.
- **Reset mid-clear:** assert `async_rst` at clear count 100 → all outputs return to their reset values asynchronously.
  - Clear restarts and takes the full 254 cycles.
